// File: rtl/itch_msg_router_if.sv
// itch_msg_router_if: bundles the router's message input, per-channel output
// and statistics signals.
//   master : the framer/decoder side (drives in_valid, msg_type, payload,
//            ch_enable, out_ready; observes everything else)
//   slave  : the router itself
interface itch_msg_router_if #(
    parameter int unsigned PAYLOAD_WIDTH = 512,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_WIDTH     = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [7:0]                      msg_type;
    logic [PAYLOAD_WIDTH-1:0]        payload;
    logic [NUM_CH-1:0]               ch_enable;
    logic [NUM_CH-1:0]               out_valid;
    logic [NUM_CH-1:0]               out_ready;
    logic [NUM_CH*PAYLOAD_WIDTH-1:0] out_payload;
    logic [CNT_WIDTH-1:0]            unknown_cnt;
    logic [CNT_WIDTH-1:0]            drop_cnt;

    modport master (
        output in_valid, msg_type, payload, ch_enable, out_ready,
        input  in_ready, out_valid, out_payload, unknown_cnt, drop_cnt
    );

    modport slave (
        input  in_valid, msg_type, payload, ch_enable, out_ready,
        output in_ready, out_valid, out_payload, unknown_cnt, drop_cnt
    );
endinterface

// File: rtl/itch_msg_router.sv
// itch_msg_router: routes each ITCH message to one of NUM_CH decoder channels
// selected by a packed type-code table. Each channel owns a 1-entry output
// register with valid/ready backpressure. Unmatched messages and (optionally)
// messages hitting a full channel are counted with saturating counters.
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active low
//   bus    itch_msg_router_if.slave: in_valid/in_ready/msg_type/payload,
//          ch_enable, out_valid/out_ready/out_payload, unknown_cnt, drop_cnt
module itch_msg_router #(
    parameter int unsigned             PAYLOAD_WIDTH = 512,
    parameter int unsigned             NUM_CH        = 4,
    parameter logic [8*NUM_CH-1:0]     CH_TYPES      = 32'h44585541,
    parameter bit                      DROP_ON_FULL  = 1'b0,
    parameter int unsigned             CNT_WIDTH     = 16
) (
    input logic             clk,
    input logic             rst_n,
    itch_msg_router_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0]               out_valid_q, out_valid_d;
    logic [NUM_CH*PAYLOAD_WIDTH-1:0] out_payload_q, out_payload_d;
    logic [CNT_WIDTH-1:0]            unknown_cnt_q, unknown_cnt_d;
    logic [CNT_WIDTH-1:0]            drop_cnt_q, drop_cnt_d;

    logic              hit;
    logic [IDX_W-1:0]  target;
    logic [NUM_CH-1:0] slot_free;
    logic              tgt_free;
    logic              accept;
    logic [NUM_CH-1:0] load_vec;

    // Type match with lowest-index priority: scanning downwards lets the
    // lowest matching channel overwrite any higher one.
    always_comb begin
        hit    = 1'b0;
        target = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (bus.ch_enable[i] && (bus.msg_type == CH_TYPES[8*i +: 8])) begin
                hit    = 1'b1;
                target = IDX_W'(i);
            end
        end
    end

    // A slot can take a new message if empty or draining this cycle.
    assign slot_free = ~out_valid_q | bus.out_ready;
    assign tgt_free  = slot_free[target];

    assign bus.in_ready = DROP_ON_FULL ? 1'b1 : (!hit || tgt_free);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        load_vec      = '0;
        out_valid_d   = out_valid_q & ~bus.out_ready;
        out_payload_d = out_payload_q;
        unknown_cnt_d = unknown_cnt_q;
        drop_cnt_d    = drop_cnt_q;

        if (accept && hit && tgt_free) begin
            load_vec[target] = 1'b1;
        end
        out_valid_d = out_valid_d | load_vec;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (load_vec[i]) begin
                out_payload_d[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = bus.payload;
            end
        end

        if (accept && !hit && (unknown_cnt_q != '1)) begin
            unknown_cnt_d = unknown_cnt_q + CNT_ONE;
        end
        // Only reachable with DROP_ON_FULL: otherwise in_ready is low here.
        if (accept && hit && !tgt_free && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= '0;
            out_payload_q <= '0;
            unknown_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
            unknown_cnt_q <= unknown_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_payload = out_payload_q;
    assign bus.unknown_cnt = unknown_cnt_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule
